ldm_ctrl: RTL

- Block-transfer sequencer for LDM/STM. It sits directly upstream of the execute stage.
- On a block-transfer instruction it expands the 16-bit register list into one transfer per cycle, lowest register first.
- Per transfer it drives the EX-stage LDM mux inputs: valid, memory-valid, register code and address offset.
- An optional trailing cycle writes back the base register. The front end stalls while the block is busy.

---
 rtl/ldm_ctrl_pkg.sv | 27 ++
 rtl/ldm_ctrl_prio_enc16.sv | 19 +
 rtl/ldm_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/ldm_ctrl_pkg.sv
// Shared encodings for the LDM/STM block-transfer sequencer.
package ldm_ctrl_pkg;

   typedef enum logic [1:0] {
      LDM_IDLE  = 2'd0,
      LDM_XFER  = 2'd1,
      LDM_WBACK = 2'd2
   } ldm_state_t;

   // Encoded as {P,U}
   typedef enum logic [1:0] {
      MODE_DA = 2'b00,
      MODE_IA = 2'b01,
      MODE_DB = 2'b10,
      MODE_IB = 2'b11
   } ldm_mode_t;

   function automatic logic [4:0] popcount16(input logic [15:0] v);
      logic [4:0] c;
      c = '0;
      for (int unsigned i = 0; i < 16; i++) begin
         c = c + 5'(v[i]);
      end
      return c;
   endfunction

endpackage

// File: rtl/ldm_ctrl_prio_enc16.sv
// 16-bit lowest-set-bit encoder; also used by the STM register-read path.
module prio_enc16 (
   input  logic [15:0] req,
   output logic [3:0]  idx,
   output logic        any
);

   always_comb begin
      idx = '0;
      any = |req;
      // Scan from the top so the lowest set bit is the last one written
      for (int unsigned i = 0; i < 16; i++) begin
         if (req[15 - i]) begin
            idx = 4'(15 - i);
         end
      end
   end

endmodule

// File: rtl/ldm_ctrl.sv
// LDM/STM block-transfer sequencer: one register per beat, lowest first,
// with an optional trailing base-writeback beat.
module ldm_ctrl
   import ldm_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned NREG   = 16
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_start,
   input  logic [NREG-1:0]          i_reg_list,
   input  logic                     i_pre,
   input  logic                     i_up,
   input  logic                     i_wback,
   input  logic [3:0]               i_base_code,
   input  logic                     i_hold,
   output logic                     o_busy,
   output logic                     o_ldm_vld,
   output logic                     o_ldm_mem_vld,
   output logic [$clog2(NREG)-1:0]  o_ldm_reg_code,
   output logic [ADDR_W-1:0]        o_ldm_offset,
   output logic                     o_base_wb_vld,
   output logic                     o_done
);

   ldm_state_t       state, state_nx;
   logic [NREG-1:0]  list, list_nx;
   logic [3:0]       k, k_nx;
   logic [4:0]       n, n_nx;
   ldm_mode_t        mode, mode_nx;
   logic             wb, wb_nx;
   logic [3:0]       rn, rn_nx;
   logic             empty_done, empty_done_nx;

   logic [3:0]       enc_idx;
   logic             enc_any;
   logic [NREG-1:0]  rest;
   logic             last_beat;
   logic [ADDR_W-1:0] k4, n4, step4;

   prio_enc16 u_enc (
      .req (list),
      .idx (enc_idx),
      .any (enc_any)
   );

   assign rest      = list & ~(NREG'(1) << enc_idx);
   assign last_beat = enc_any & ~|rest;
   assign k4        = ADDR_W'({k, 2'b00});
   assign n4        = ADDR_W'({n, 2'b00});
   assign step4     = ADDR_W'(4);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state      <= LDM_IDLE;
         list       <= '0;
         k          <= '0;
         n          <= '0;
         mode       <= MODE_DA;
         wb         <= 1'b0;
         rn         <= '0;
         empty_done <= 1'b0;
      end else begin
         state      <= state_nx;
         list       <= list_nx;
         k          <= k_nx;
         n          <= n_nx;
         mode       <= mode_nx;
         wb         <= wb_nx;
         rn         <= rn_nx;
         empty_done <= empty_done_nx;
      end
   end

   always_comb begin
      state_nx      = state;
      list_nx       = list;
      k_nx          = k;
      n_nx          = n;
      mode_nx       = mode;
      wb_nx         = wb;
      rn_nx         = rn;
      empty_done_nx = 1'b0;
      if (i_hold) begin
         empty_done_nx = empty_done;
      end else begin
         unique case (state)
            LDM_IDLE: begin
               if (i_start) begin
                  if (|i_reg_list) begin
                     state_nx = LDM_XFER;
                     list_nx  = i_reg_list;
                     k_nx     = '0;
                     n_nx     = popcount16(i_reg_list);
                     mode_nx  = ldm_mode_t'({i_pre, i_up});
                     wb_nx    = i_wback;
                     rn_nx    = i_base_code;
                  end else begin
                     empty_done_nx = 1'b1;
                  end
               end
            end
            LDM_XFER: begin
               list_nx = rest;
               k_nx    = k + 4'd1;
               if (last_beat) begin
                  state_nx = wb ? LDM_WBACK : LDM_IDLE;
               end
            end
            LDM_WBACK: state_nx = LDM_IDLE;
            default:   state_nx = LDM_IDLE;
         endcase
      end
   end

   always_comb begin
      o_busy         = (state != LDM_IDLE);
      o_ldm_vld      = 1'b0;
      o_ldm_mem_vld  = 1'b0;
      o_base_wb_vld  = 1'b0;
      o_done         = 1'b0;
      o_ldm_reg_code = '0;
      o_ldm_offset   = '0;
      unique case (state)
         LDM_IDLE: o_done = empty_done;
         LDM_XFER: begin
            o_ldm_vld      = 1'b1;
            o_ldm_mem_vld  = 1'b1;
            o_ldm_reg_code = enc_idx;
            o_done         = last_beat & ~wb;
            unique case (mode)
               MODE_IA: o_ldm_offset = k4;
               MODE_IB: o_ldm_offset = k4 + step4;
               MODE_DA: o_ldm_offset = k4 - n4 + step4;
               MODE_DB: o_ldm_offset = k4 - n4;
               default: o_ldm_offset = '0;
            endcase
         end
         LDM_WBACK: begin
            o_ldm_vld      = 1'b1;
            o_base_wb_vld  = 1'b1;
            o_ldm_reg_code = rn;
            o_ldm_offset   = (mode == MODE_IA || mode == MODE_IB) ? n4 : ('0 - n4);
            o_done         = 1'b1;
         end
         default: ;
      endcase
   end

endmodule
